// File: rtl/present_encryptor_ctrl.sv
// present_encryptor_ctrl: request/response sequencer for an external PRESENT-80 core.
// Loads the key and then the plaintext into the core, waits CORE_LATENCY cycles,
// captures the ciphertext and holds it until the consumer takes it.
// Optional build macro: PRESENT_KEY_CACHE_EN -- remembers the last key loaded into the
// core and skips the key-load step when a new request carries the same key.
module present_encryptor_ctrl #(
    parameter int unsigned CORE_LATENCY = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [79:0] req_key_i,
    input  logic [63:0] req_pt_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_ct_o,
    output logic        busy_o,
    output logic [79:0] core_data_o,
    output logic        core_key_load_o,
    output logic        core_data_load_o,
    input  logic [63:0] core_data_i
);

    localparam int unsigned     CNT_W    = $clog2(CORE_LATENCY + 1);
    // RUN starts the cycle after LOAD_DATA, so the count reaching CORE_LATENCY-1
    // marks the cycle exactly CORE_LATENCY cycles after the data load.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_DATA,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [79:0]        key_q, key_d;
    logic [63:0]        pt_q, pt_d;
    logic [63:0]        ct_q, ct_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               key_hit;

`ifdef PRESENT_KEY_CACHE_EN
    logic [79:0]        cache_key_q;
    logic               cache_vld_q;

    assign key_hit = cache_vld_q && (req_key_i == cache_key_q);

    // Track the key currently held by the core; every key load refreshes it
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cache_key_q <= '0;
            cache_vld_q <= 1'b0;
        end else if (state_q == LOAD_KEY) begin
            cache_key_q <= key_q;
            cache_vld_q <= 1'b1;
        end
    end
`else
    assign key_hit = 1'b0;
`endif

    assign busy_o   = (state_q != IDLE);
    assign rsp_ct_o = ct_q;

    // Next-state, request capture and core strobe generation
    always_comb begin
        state_d          = state_q;
        key_d            = key_q;
        pt_d             = pt_q;
        ct_d             = ct_q;
        cnt_d            = cnt_q;
        req_ready_o      = 1'b0;
        rsp_valid_o      = 1'b0;
        core_data_o      = '0;
        core_key_load_o  = 1'b0;
        core_data_load_o = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    key_d   = req_key_i;
                    pt_d    = req_pt_i;
                    state_d = key_hit ? LOAD_DATA : LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                core_key_load_o = 1'b1;
                core_data_o     = key_q;
                state_d         = LOAD_DATA;
            end
            LOAD_DATA: begin
                core_data_load_o = 1'b1;
                core_data_o      = {16'h0000, pt_q};
                cnt_d            = '0;
                state_d          = RUN;
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    ct_d    = core_data_i;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            key_q   <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_present_encryptor_ctrl.sv
// tb_present_encryptor_ctrl: directed bench for present_encryptor_ctrl with a
// behavioural PRESENT-80 core that shows the ciphertext only in the one cycle
// CORE_LATENCY cycles after its data load.
module tb_present_encryptor_ctrl;

    localparam int unsigned CL = 32;

`ifdef PRESENT_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [79:0] K0 = '0;
    localparam logic [79:0] K1 = '1;
    localparam logic [63:0] P0 = '0;
    localparam logic [63:0] P1 = '1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [79:0] req_key;
    logic [63:0] req_pt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_ct;
    logic        busy;
    logic [79:0] core_data;
    logic        core_key_load;
    logic        core_data_load;
    logic [63:0] core_data_in;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    present_encryptor_ctrl #(
        .CORE_LATENCY(CL)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_key_i       (req_key),
        .req_pt_i        (req_pt),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_ct_o        (rsp_ct),
        .busy_o          (busy),
        .core_data_o     (core_data),
        .core_key_load_o (core_key_load),
        .core_data_load_o(core_data_load),
        .core_data_i     (core_data_in)
    );

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: sbox4 = 4'hC;  4'h1: sbox4 = 4'h5;  4'h2: sbox4 = 4'h6;  4'h3: sbox4 = 4'hB;
            4'h4: sbox4 = 4'h9;  4'h5: sbox4 = 4'h0;  4'h6: sbox4 = 4'hA;  4'h7: sbox4 = 4'hD;
            4'h8: sbox4 = 4'h3;  4'h9: sbox4 = 4'hE;  4'hA: sbox4 = 4'hF;  4'hB: sbox4 = 4'h8;
            4'hC: sbox4 = 4'h4;  4'hD: sbox4 = 4'h7;  4'hE: sbox4 = 4'h1;  default: sbox4 = 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] present80(input logic [79:0] key_in, input logic [63:0] pt_in);
        logic [79:0] k;
        logic [63:0] s;
        logic [63:0] t;
        k = key_in;
        s = pt_in;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int j = 0; j < 16; j++) t[4*j +: 4] = sbox4(s[4*j +: 4]);
            for (int b = 0; b < 63; b++) s[(b * 16) % 63] = t[b];
            s[63] = t[63];
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox4(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // Behavioural core: latches key/plaintext on the strobes, ciphertext visible only at t == CL
    logic [79:0] mdl_key;
    logic [63:0] mdl_ct;
    int unsigned mdl_t = 0;

    always @(posedge clk) begin
        if (core_key_load) mdl_key <= core_data;
        if (core_data_load) begin
            mdl_ct <= present80(mdl_key, core_data[63:0]);
            mdl_t  <= 1;
        end else if (mdl_t != 0 && mdl_t < 1000) begin
            mdl_t <= mdl_t + 1;
        end
    end

    assign core_data_in = (mdl_t == CL) ? mdl_ct : ~mdl_ct;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Strobes exclusive; core bus idle whenever no strobe is up
    always @(negedge clk) begin
        if (mon_en) begin
            check("strobe_excl", 80'(core_key_load & core_data_load), 80'd0);
            if (core_key_load === 1'b0 && core_data_load === 1'b0)
                check("core_data_idle", core_data, 80'd0);
        end
    end

    // Called at a negedge in IDLE; returns at a negedge in IDLE after the handshake
    task automatic run_req(input string tag, input logic [79:0] key, input logic [63:0] pt,
                           input logic [63:0] exp_ct, input bit exp_kl, input int hold,
                           input bit disturb);
        int  n;
        int  kl_cnt;
        int  dl_cnt;
        bit  got_rsp;
        n = 0; kl_cnt = 0; dl_cnt = 0; got_rsp = 1'b0;
        check({tag, "/ready_idle"}, 80'(req_ready), 80'd1);
        req_valid = 1'b1;
        req_key   = key;
        req_pt    = pt;
        @(posedge clk); #1;
        req_valid = disturb;
        req_key   = ~key;
        req_pt    = ~pt;
        while (!got_rsp && n < int'(CL) + 20) begin
            @(negedge clk);
            n++;
            if (core_key_load === 1'b1) begin
                kl_cnt++;
                check({tag, "/key_bus"}, core_data, key);
            end
            if (core_data_load === 1'b1) begin
                dl_cnt++;
                check({tag, "/pt_bus"}, core_data, {16'h0000, pt});
            end
            if (rsp_valid === 1'b1) got_rsp = 1'b1;
            else check({tag, "/ready_busy"}, 80'(req_ready), 80'd0);
        end
        check({tag, "/latency"}, 80'(n), exp_kl ? 80'(CL + 3) : 80'(CL + 2));
        check({tag, "/ct"}, 80'(rsp_ct), 80'(exp_ct));
        check({tag, "/key_loads"}, 80'(kl_cnt), 80'(exp_kl));
        check({tag, "/data_loads"}, 80'(dl_cnt), 80'd1);
        check({tag, "/busy_done"}, 80'(busy), 80'd1);
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, 80'(rsp_valid), 80'd1);
            check({tag, "/hold_ct"}, 80'(rsp_ct), 80'(exp_ct));
            check({tag, "/hold_ready"}, 80'(req_ready), 80'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "/post_valid"}, 80'(rsp_valid), 80'd0);
        check({tag, "/post_busy"}, 80'(busy), 80'd0);
        check({tag, "/post_ready"}, 80'(req_ready), 80'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_key   = '0;
        req_pt    = '0;
        rsp_ready = 1'b1;

        // Reset state while reset is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst/ready", 80'(req_ready), 80'd1);
        check("rst/valid", 80'(rsp_valid), 80'd0);
        check("rst/busy", 80'(busy), 80'd0);
        check("rst/ct", 80'(rsp_ct), 80'd0);
        check("rst/strobes", 80'({core_key_load, core_data_load}), 80'd0);
        check("rst/core_data", core_data, 80'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b0;
        mon_en    = 1'b1;

        // Reference vectors, each with a fresh key load
        run_req("k0p0", K0, P0, 64'h5579C1387B228445, 1'b1, 0, 1'b0);
        run_req("k1p0", K1, P0, 64'hE72C46C0F5945049, 1'b1, 0, 1'b0);
        run_req("k0p1", K0, P1, 64'hA112FFC72F68417B, 1'b1, 0, 1'b0);
        run_req("k1p1", K1, P1, 64'h3333DCD3213210D2, 1'b1, 0, 1'b0);

        // Back-to-back identical keys: the second may hit the key cache
        run_req("b2b_a", K0, P0, 64'h5579C1387B228445, 1'b1, 0, 1'b0);
        run_req("b2b_b", K0, P0, 64'h5579C1387B228445, !CACHE_EN, 0, 1'b0);

        // Consumer stalls 10 cycles in DONE
        run_req("stall", K0, P1, 64'hA112FFC72F68417B, !CACHE_EN, 10, 1'b0);

        // New request presented throughout the operation must be ignored
        run_req("ignore", K1, P0, 64'hE72C46C0F5945049, 1'b1, 0, 1'b1);

        // Reset in RUN abandons the request and invalidates the key cache
        check("rrun/ready", 80'(req_ready), 80'd1);
        req_valid = 1'b1;
        req_key   = K1;
        req_pt    = P1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("rrun/busy_run", 80'(busy), 80'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rrun/valid", 80'(rsp_valid), 80'd0);
        check("rrun/busy", 80'(busy), 80'd0);
        check("rrun/ready_after", 80'(req_ready), 80'd1);
        check("rrun/ct", 80'(rsp_ct), 80'd0);
        repeat (CL + 4) @(negedge clk);
        check("rrun/no_rsp", 80'(rsp_valid), 80'd0);
        run_req("after_rst", K1, P1, 64'h3333DCD3213210D2, 1'b1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
